sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//   Parametrised single-clock FIFO. It is the successor to the gray-pointer async FIFO, for paths
//   where writer and reader share clka. Compared with that FIFO it adds:
//   - configurable data width and depth
//   - selectable read mode: registered (1-cycle latency) or first-word-fall-through (FWFT)
//   - programmable almost-full / almost-empty flags
//   - fill-level output
//   - sticky overflow / underflow error flags
// PARAMETERS
//   DW      8   data width in bits
//   AW      4   address width; DEPTH = 2**AW entries (16)
//   FWFT    0   0 = registered read, 1 = first-word-fall-through
//   AF_LVL  14  afull asserted when level >= AF_LVL (range 1..DEPTH)
//   AE_LVL  2   aempty asserted when level <= AE_LVL (range 0..DEPTH-1)
// PORTS
//   clka    in   1     clock, rising edge
//   rstna   in   1     synchronous reset, active low
//   wreq    in   1     write request
//   wdata   in   DW    write data
//   full    out  1     FIFO holds DEPTH entries
//   afull   out  1     almost full
//   rreq    in   1     read request (FWFT: pop/acknowledge the head word)
//   rdata   out  DW    read data
//   rvalid  out  1     rdata valid
//   empty   out  1     FIFO holds 0 entries
//   aempty  out  1     almost empty
//   level   out  AW+1  current entry count, 0..DEPTH
//   ovf     out  1     sticky: write attempted while full
//   udf     out  1     sticky: read attempted while empty
//   clr_err in   1     clears ovf/udf
// BEHAVIOUR
//   Reset (rstna=0 at posedge clka)
//   - wr_ptr = rd_ptr = 0, level = 0.
//   - empty = 1, aempty = 1, full = 0, afull = 0.
//   - rvalid = 0, rdata = 0, ovf = 0, udf = 0.
//   - Storage contents are not reset.
//   - Reset mid-operation discards all entries; a read in flight does not produce rvalid.
//   Accepted operations (evaluated on the registered flags of the current cycle)
//   - wr_en = wreq & ~full.
//   - rd_en = rreq & ~empty.
//   - A write while full is dropped and sets ovf. This holds even if rd_en is asserted in the same
//     cycle: full blocks the write regardless of a concurrent pop.
//   - A read while empty is ignored and sets udf. This holds even if wreq is asserted in the same
//     cycle: no write-through.
//   Pointers
//   - AW-bit pointers; they wrap DEPTH-1 -> 0 naturally.
//   - wr_en writes mem[wr_ptr] and increments wr_ptr.
//   - rd_en increments rd_ptr.
//   Level and flags (all registered, updated together at the edge)
//   - level_next = level + wr_en - rd_en; simultaneous wr_en & rd_en keeps level unchanged.
//   - full = (level_next == DEPTH); empty = (level_next == 0).
//   - afull = (level_next >= AF_LVL); aempty = (level_next <= AE_LVL).
//   FWFT=0
//   - On rd_en, rdata <= mem[rd_ptr] and rvalid <= 1 on the next edge; otherwise rvalid <= 0.
//   - rdata holds its last value while rvalid = 0.
//   - Read latency is 1 cycle; back-to-back rreq gives one word per cycle.
//   FWFT=1
//   - rvalid = ~empty; rdata = empty ? 0 : mem[rd_ptr] (combinational from registered state).
//   - A word written at edge N is visible at rdata after edge N, since empty deasserts at that edge.
//   - rreq with rvalid pops the head word; the next word appears after the same edge.
//   Error flags
//   - ovf/udf stay set until clr_err = 1.
//   - If clr_err is asserted in the same cycle as a new error, the set wins.
// TESTING
//   1. Reset, then 16 writes 0x00..0x0F with no reads -> full=1 and level=16 after the 16th edge;
//      afull=1 from level 14 on.
//   2. Continuing from 1: wreq with wdata=0xAA while full -> data is dropped, ovf=1, level stays 16;
//      clr_err -> ovf=0.
//   3. FWFT=0: read all 16 -> rdata 0x00..0x0F, each one cycle after its rreq; empty=1 after the
//      last pop. One extra rreq -> udf=1, rvalid=0.
//   4. Continuous simultaneous wreq/rreq at level 5 for 40 cycles (pointers wrap twice) ->
//      level stays 5, data order is preserved, full and empty never assert.
//   5. FWFT=1: write 0x5C into an empty FIFO -> rvalid=1 and rdata=0x5C the next cycle with no
//      rreq; rreq -> empty=1, rdata=0.
//   6. Assert rstna=0 for one cycle at level 9 with rreq pending -> level=0, empty=1, rvalid=0;
//      the FIFO accepts normal traffic afterwards.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param; master drives requests, slave is the FIFO.
interface sync_fifo_param_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
);
  logic          wreq;
  logic [DW-1:0] wdata;
  logic          full;
  logic          afull;
  logic          rreq;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          empty;
  logic          aempty;
  logic [AW:0]   level;
  logic          ovf;
  logic          udf;
  logic          clr_err;

  modport master (
    output wreq, wdata, rreq, clr_err,
    input  full, afull, rdata, rvalid, empty, aempty, level, ovf, udf
  );

  modport slave (
    input  wreq, wdata, rreq, clr_err,
    output full, afull, rdata, rvalid, empty, aempty, level, ovf, udf
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered or first-word-fall-through read, level/almost flags and
// sticky overflow/underflow errors.
module sync_fifo_param #(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 4,
  parameter int unsigned FWFT   = 0,
  parameter int unsigned AF_LVL = 14,
  parameter int unsigned AE_LVL = 2
) (
  input logic              clka,
  input logic              rstna,
  sync_fifo_param_if.slave bus
);

  localparam int unsigned Depth  = 2 ** AW;
  localparam logic [AW:0] DepthL = (AW+1)'(Depth);
  localparam logic [AW:0] AfLvl  = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AeLvl  = (AW+1)'(AE_LVL);

  logic [DW-1:0] mem [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          full_q, empty_q, afull_q, aempty_q;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          wr_en, rd_en;

  // Acceptance uses only the registered flags: no write-through, no pop-through on full.
  assign wr_en = bus.wreq & ~full_q;
  assign rd_en = bus.rreq & ~empty_q;

  always_comb begin
    level_d = level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    // A new error overrides a same-cycle clear.
    if (bus.wreq && full_q)  ovf_d = 1'b1;
    if (bus.rreq && empty_q) udf_d = 1'b1;
  end

  always_ff @(posedge clka) begin
    if (!rstna) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q  <= level_d;
      full_q   <= (level_d == DepthL);
      empty_q  <= (level_d == '0);
      afull_q  <= (level_d >= AfLvl);
      aempty_q <= (level_d <= AeLvl);
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clka) begin
    if (rstna && wr_en) mem[wr_ptr_q] <= bus.wdata;
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.rvalid = ~empty_q;
    assign bus.rdata  = empty_q ? '0 : mem[rd_ptr_q];
  end else begin : g_reg
    logic [DW-1:0] rdata_q;
    logic          rvalid_q;

    always_ff @(posedge clka) begin
      if (!rstna) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_en;
        if (rd_en) rdata_q <= mem[rd_ptr_q];
      end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
  end

  assign bus.full   = full_q;
  assign bus.empty  = empty_q;
  assign bus.afull  = afull_q;
  assign bus.aempty = aempty_q;
  assign bus.level  = level_q;
  assign bus.ovf    = ovf_q;
  assign bus.udf    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: one FIFO in registered-read mode (a) and one in FWFT mode (b).
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rstn_a = 1'b0;
  logic rstn_b = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DW(8), .AW(4)) bus_a ();
  sync_fifo_param_if #(.DW(8), .AW(4)) bus_b ();

  sync_fifo_param #(.DW(8), .AW(4), .FWFT(0), .AF_LVL(14), .AE_LVL(2)) dut_a (
    .clka  (clk),
    .rstna (rstn_a),
    .bus   (bus_a)
  );

  sync_fifo_param #(.DW(8), .AW(4), .FWFT(1), .AF_LVL(14), .AE_LVL(2)) dut_b (
    .clka  (clk),
    .rstna (rstn_b),
    .bus   (bus_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Registered mode: every rvalid cycle must deliver the oldest accepted word.
  always @(negedge clk) begin
    if (bus_a.rvalid === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_rvalid: got rdata %0h expected no output", bus_a.rdata);
      end else begin
        chk("a_rdata", 32'(bus_a.rdata), 32'(qa.pop_front()));
      end
    end
  end

  // FWFT mode: the head word is checked at the cycle it is acknowledged.
  always @(negedge clk) begin
    if (bus_b.rvalid === 1'b1 && bus_b.rreq === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_pop: got rdata %0h expected no output", bus_b.rdata);
      end else begin
        chk("b_rdata", 32'(bus_b.rdata), 32'(qb.pop_front()));
      end
    end
  end

  initial begin
    bus_a.wreq = 0; bus_a.wdata = '0; bus_a.rreq = 0; bus_a.clr_err = 0;
    bus_b.wreq = 0; bus_b.wdata = '0; bus_b.rreq = 0; bus_b.clr_err = 0;
    step();
    step();
    rstn_a = 1'b1;
    rstn_b = 1'b1;

    // Reset state
    chk("rst_empty", 32'(bus_a.empty), 1);
    chk("rst_aempty", 32'(bus_a.aempty), 1);
    chk("rst_full", 32'(bus_a.full), 0);
    chk("rst_afull", 32'(bus_a.afull), 0);
    chk("rst_level", 32'(bus_a.level), 0);
    chk("rst_rvalid", 32'(bus_a.rvalid), 0);
    chk("rst_rdata", 32'(bus_a.rdata), 0);
    chk("rst_ovf", 32'(bus_a.ovf), 0);
    chk("rst_udf", 32'(bus_a.udf), 0);

    // 1: fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      bus_a.wreq = 1; bus_a.wdata = 8'(i);
      qa.push_back(8'(i));
      step();
      chk("fill_level", 32'(bus_a.level), 32'(i + 1));
      chk("fill_afull", 32'(bus_a.afull), (i + 1 >= 14) ? 1 : 0);
      chk("fill_aempty", 32'(bus_a.aempty), (i + 1 <= 2) ? 1 : 0);
      chk("fill_full", 32'(bus_a.full), (i + 1 == 16) ? 1 : 0);
      chk("fill_empty", 32'(bus_a.empty), 0);
    end

    // 2: write while full is dropped
    bus_a.wdata = 8'hAA;
    step();
    bus_a.wreq = 0;
    chk("ovf_set", 32'(bus_a.ovf), 1);
    chk("ovf_level", 32'(bus_a.level), 16);
    chk("ovf_full", 32'(bus_a.full), 1);
    bus_a.clr_err = 1;
    step();
    bus_a.clr_err = 0;
    chk("ovf_clear", 32'(bus_a.ovf), 0);

    // 3: drain; each word arrives one edge after its rreq
    for (int i = 0; i < 16; i++) begin
      bus_a.rreq = 1;
      step();
      chk("drain_rvalid", 32'(bus_a.rvalid), 1);
      chk("drain_level", 32'(bus_a.level), 32'(15 - i));
    end
    chk("drain_empty", 32'(bus_a.empty), 1);
    step();
    bus_a.rreq = 0;
    chk("udf_set", 32'(bus_a.udf), 1);
    chk("udf_rvalid", 32'(bus_a.rvalid), 0);
    chk("drain_rdata_hold", 32'(bus_a.rdata), 32'h0F);
    bus_a.clr_err = 1;
    step();
    bus_a.clr_err = 0;
    chk("udf_clear", 32'(bus_a.udf), 0);

    // 4: steady state at level 5 with simultaneous push/pop, wrapping pointers
    for (int i = 0; i < 5; i++) begin
      bus_a.wreq = 1; bus_a.wdata = 8'(8'h30 + i);
      qa.push_back(8'(8'h30 + i));
      step();
    end
    chk("ss_level0", 32'(bus_a.level), 5);
    for (int i = 0; i < 40; i++) begin
      bus_a.wreq = 1; bus_a.rreq = 1; bus_a.wdata = 8'(8'h40 + i);
      qa.push_back(8'(8'h40 + i));
      step();
      chk("ss_level", 32'(bus_a.level), 5);
      chk("ss_full", 32'(bus_a.full), 0);
      chk("ss_empty", 32'(bus_a.empty), 0);
    end
    bus_a.wreq = 0;
    for (int i = 0; i < 5; i++) step();
    bus_a.rreq = 0;
    step();
    chk("ss_drained", 32'(qa.size()), 0);
    chk("ss_empty_end", 32'(bus_a.empty), 1);

    // 6: reset at level 9 with a read pending
    for (int i = 0; i < 9; i++) begin
      bus_a.wreq = 1; bus_a.wdata = 8'(8'h90 + i);
      qa.push_back(8'(8'h90 + i));
      step();
    end
    bus_a.wreq = 0;
    chk("mr_level9", 32'(bus_a.level), 9);
    rstn_a = 1'b0; bus_a.rreq = 1;
    step();
    rstn_a = 1'b1; bus_a.rreq = 0;
    qa.delete();
    chk("mr_level", 32'(bus_a.level), 0);
    chk("mr_empty", 32'(bus_a.empty), 1);
    chk("mr_rvalid", 32'(bus_a.rvalid), 0);
    bus_a.wreq = 1; bus_a.wdata = 8'h77;
    qa.push_back(8'h77);
    step();
    bus_a.wreq = 0;
    chk("mr_after_level", 32'(bus_a.level), 1);
    bus_a.rreq = 1;
    step();
    bus_a.rreq = 0;
    chk("mr_after_rvalid", 32'(bus_a.rvalid), 1);
    step();
    chk("mr_after_drained", 32'(qa.size()), 0);

    // 5: FWFT mode
    chk("b_rst_rvalid", 32'(bus_b.rvalid), 0);
    chk("b_rst_rdata", 32'(bus_b.rdata), 0);
    bus_b.wreq = 1; bus_b.wdata = 8'h5C;
    qb.push_back(8'h5C);
    step();
    bus_b.wreq = 0;
    chk("b_fall_rvalid", 32'(bus_b.rvalid), 1);
    chk("b_fall_rdata", 32'(bus_b.rdata), 32'h5C);
    chk("b_fall_level", 32'(bus_b.level), 1);
    step();
    chk("b_hold_rdata", 32'(bus_b.rdata), 32'h5C);
    bus_b.rreq = 1;
    step();
    bus_b.rreq = 0;
    chk("b_pop_empty", 32'(bus_b.empty), 1);
    chk("b_pop_rdata", 32'(bus_b.rdata), 0);
    chk("b_pop_rvalid", 32'(bus_b.rvalid), 0);
    for (int i = 0; i < 3; i++) begin
      bus_b.wreq = 1; bus_b.wdata = 8'(8'hA1 + i);
      qb.push_back(8'(8'hA1 + i));
      step();
    end
    bus_b.wreq = 0;
    chk("b_head", 32'(bus_b.rdata), 32'hA1);
    bus_b.rreq = 1;
    for (int i = 0; i < 3; i++) step();
    chk("b_burst_empty", 32'(bus_b.empty), 1);
    step();
    bus_b.rreq = 0;
    chk("b_udf", 32'(bus_b.udf), 1);
    chk("b_drained", 32'(qb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
